// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector datapath: element/row defaults,
// the loader state encoding and a small width helper.
package mvm_pkg;

    localparam int MVM_DATA_WIDTH = 8;
    localparam int MVM_DEPTH      = 8;
    localparam int MVM_LINE_WIDTH = MVM_DATA_WIDTH * MVM_DEPTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_REQ,
        ST_WAIT_DATA,
        ST_STREAM_B,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_vec_loader_if.sv
// Avalon-style read bus between the loader (master) and the memory wrapper (slave).
interface mat_vec_loader_if
    import mvm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = MVM_LINE_WIDTH
);

    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  waitrequest;
    logic [LINE_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/mat_vec_loader_line_serializer.sv
// Holds one vector line and emits its DEPTH elements, highest lane first,
// one per cycle with a valid strobe and a last flag on the final element.
module line_serializer
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = MVM_DATA_WIDTH,
    parameter int DEPTH      = MVM_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [DATA_WIDTH*DEPTH-1:0] line,
    output logic                        valid,
    output logic [DATA_WIDTH-1:0]       data,
    output logic                        last
);

    localparam int LINE_W = DATA_WIDTH * DEPTH;
    localparam int IDX_W  = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [LINE_W-1:0] shreg;
    logic [IDX_W-1:0]  b_idx;
    logic              active;

    // The top lane is always the one on the output; shifting left exposes the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            b_idx  <= '0;
            active <= 1'b0;
        end else if (load) begin
            shreg  <= line;
            b_idx  <= '0;
            active <= 1'b1;
        end else if (active) begin
            shreg <= shreg << DATA_WIDTH;
            if (last) begin
                active <= 1'b0;
                b_idx  <= '0;
            end else begin
                b_idx <= b_idx + IDX_W'(1);
            end
        end
    end

    assign valid = active;
    assign data  = shreg[LINE_W-1 -: DATA_WIDTH];
    assign last  = active && (b_idx == LAST_IDX);

endmodule

// File: rtl/mat_vec_loader.sv
// Read master that fetches DEPTH matrix rows and one vector line from memory,
// writes the rows to the A FIFOs and serialises the vector into the B input.
module mat_vec_loader
    import mvm_pkg::*;
#(
    parameter int                    DATA_WIDTH = MVM_DATA_WIDTH,
    parameter int                    DEPTH      = MVM_DEPTH,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    mat_vec_loader_if.master            mem,
    output logic                        clr,
    output logic                        a_wren,
    output logic [DATA_WIDTH*DEPTH-1:0] a_row,
    output logic                        b_wren,
    output logic [DATA_WIDTH-1:0]       b_byte,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int LIDX_W = $clog2(DEPTH + 1);
    localparam int WCNT_W = idx_width(TIMEOUT + 1);
    localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [LIDX_W-1:0]     line_idx;
    logic [WCNT_W-1:0]     wait_cnt;
    logic                  timed_out;
    logic                  read_req;
    logic                  row_capture;
    logic                  vec_load;
    logic                  ser_valid;
    logic                  ser_last;
    logic [DATA_WIDTH-1:0] ser_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The wait counter restarts on every state change, so each REQ and each
    // WAIT_DATA visit gets its own TIMEOUT budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_idx <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == ST_IDLE || state == ST_DONE || state == ST_ERROR) begin
                line_idx <= '0;
            end else if (row_capture) begin
                line_idx <= line_idx + LIDX_W'(1);
            end

            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state == ST_REQ || state == ST_WAIT_DATA) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_wren <= 1'b0;
            a_row  <= '0;
        end else begin
            a_wren <= row_capture;
            if (row_capture) begin
                a_row <= mem.readdata;
            end
        end
    end

    assign timed_out = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next  = state;
        clr         = 1'b0;
        read_req    = 1'b0;
        row_capture = 1'b0;
        vec_load    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr        = 1'b1;
                state_next = ST_REQ;
            end
            ST_REQ: begin
                read_req = 1'b1;
                if (!mem.waitrequest) begin
                    state_next = ST_WAIT_DATA;
                end else if (timed_out) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WAIT_DATA: begin
                if (mem.readdatavalid) begin
                    if (line_idx != LAST_LINE) begin
                        row_capture = 1'b1;
                        state_next  = ST_REQ;
                    end else begin
                        vec_load   = 1'b1;
                        state_next = ST_STREAM_B;
                    end
                end else if (timed_out) begin
                    state_next = ST_ERROR;
                end
            end
            ST_STREAM_B: begin
                if (ser_last) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    line_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_serializer (
        .clk   (clk),
        .rst   (rst),
        .load  (vec_load),
        .line  (mem.readdata),
        .valid (ser_valid),
        .data  (ser_data),
        .last  (ser_last)
    );

    assign mem.read    = read_req;
    assign mem.address = BASE_ADDR + ADDR_WIDTH'(line_idx);

    assign b_wren = ser_valid;
    assign b_byte = ser_data;
    assign busy   = (state == ST_CLEAR) || (state == ST_REQ) ||
                    (state == ST_WAIT_DATA) || (state == ST_STREAM_B);
    assign done   = (state == ST_DONE);
    assign err    = (state == ST_ERROR);

endmodule

// File: tb/tb_mat_vec_loader.sv
// Scoreboard bench for mat_vec_loader: a memory model answers reads, expected
// A rows and B bytes are queued per job and popped by an independent monitor.
module tb_mat_vec_loader;

    localparam int              DW   = 8;
    localparam int              DEP  = 8;
    localparam int              AW   = 32;
    localparam int              LW   = DW * DEP;
    localparam logic [AW-1:0]   BASE = 32'h0000_0040;
    localparam int              TMO  = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clr;
    logic          a_wren;
    logic [LW-1:0] a_row;
    logic          b_wren;
    logic [DW-1:0] b_byte;
    logic          busy;
    logic          done;
    logic          err;

    mat_vec_loader_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) mem ();

    mat_vec_loader #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mem    (mem),
        .clr    (clr),
        .a_wren (a_wren),
        .a_row  (a_row),
        .b_wren (b_wren),
        .b_byte (b_byte),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [LW-1:0] lines [DEP+1];
    logic [LW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];

    int n_compared = 0;
    int n_failed   = 0;

    int start_cyc = 0;
    int clr_count = 0;
    int b_count   = 0;
    int b_first   = -1;
    int b_last    = -1;
    int accept_count = 0;
    int accept_cyc   = 0;

    int stall_line    = -1;
    int stall_left    = 0;
    bit stall_started = 1'b0;
    int drop_line     = -1;
    bit spurious      = 1'b0;
    bit rand_wait     = 1'b0;
    bit rand_lat      = 1'b0;
    bit stray         = 1'b0;

    bit ret_pending = 1'b0;
    int ret_wait    = 0;
    int ret_line    = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic fillLines(input bit directed);
        for (int k = 0; k <= DEP; k++) begin
            if (directed) begin
                lines[k] = (k < DEP) ? {DEP{8'(k)}} : 64'h0102_0304_0506_0708;
            end else begin
                lines[k] = {$urandom, $urandom};
            end
        end
    endtask

    // Reference: rows go out in address order, vector elements highest lane first.
    task automatic applyStimulus(input int n_rows, input int n_bytes);
        exp_a.delete();
        exp_b.delete();
        for (int k = 0; k < n_rows; k++) exp_a.push_back(lines[k]);
        for (int k = 0; k < n_bytes; k++) exp_b.push_back(lines[DEP][LW-1-k*DW -: DW]);
        clr_count    = 0;
        b_count      = 0;
        b_first      = -1;
        b_last       = -1;
        accept_count = 0;
        start        = 1'b1;
        start_cyc    = cyc;
        @(negedge clk);
        start = 1'b0;
        checkOutput("clr_after_start", clr, 1);
        checkOutput("done_drop", done, 0);
        checkOutput("err_drop", err, 0);
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic waitJob(input int mid_start, output int end_cyc);
        end_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ((cyc - start_cyc) == mid_start);
            if (done || err) begin
                end_cyc = cyc - start_cyc;
                start   = 1'b0;
                break;
            end
        end
        start = 1'b0;
        if (end_cyc < 0) checkOutput("job_finished", done | err, 1);
    endtask

    task automatic checkJob(input int extra, input bit timed, input int end_cyc);
        checkOutput("job_done", done, 1);
        checkOutput("job_err", err, 0);
        checkOutput("job_busy", busy, 0);
        checkOutput("clr_count", clr_count, 1);
        checkOutput("accepts", accept_count, DEP + 1);
        checkOutput("a_left", exp_a.size(), 0);
        checkOutput("b_left", exp_b.size(), 0);
        checkOutput("b_count", b_count, DEP);
        if (timed) begin
            checkOutput("b_first_cycle", b_first, 20 + extra);
            checkOutput("b_last_cycle", b_last, 27 + extra);
            checkOutput("done_cycle", end_cyc, 28 + extra);
        end
    endtask

    // Memory model: decides waitrequest for the coming edge and returns
    // accepted lines after a 1..3 cycle latency.
    initial begin
        int idx;
        mem.waitrequest   = 1'b0;
        mem.readdata      = '0;
        mem.readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            mem.readdatavalid = 1'b0;
            mem.readdata      = {$urandom, $urandom};
            if (ret_pending) begin
                if (ret_wait == 0) begin
                    mem.readdatavalid = 1'b1;
                    mem.readdata      = lines[ret_line];
                    ret_pending       = 1'b0;
                end else begin
                    ret_wait--;
                end
            end
            if (stray) mem.readdatavalid = 1'b1;
            mem.waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (stall_left > 0 && (stall_started || (mem.read && accept_count == stall_line))) begin
                stall_started   = 1'b1;
                mem.waitrequest = 1'b1;
                checkOutput("stall_read", mem.read, 1);
                checkOutput("stall_addr", mem.address, BASE + AW'(stall_line));
                stall_left--;
                if (spurious) mem.readdatavalid = 1'b1;
            end
            if (mem.read && !mem.waitrequest) begin
                checkOutput("accept_addr", mem.address, BASE + AW'(accept_count));
                checkOutput("one_outstanding", ret_pending, 0);
                idx = (accept_count > DEP) ? DEP : accept_count;
                accept_count++;
                accept_cyc = cyc;
                if (idx != drop_line) begin
                    ret_pending = 1'b1;
                    ret_wait    = rand_lat ? int'($urandom_range(0, 2)) : 0;
                    ret_line    = idx;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes A or B.
    initial begin
        forever begin
            @(negedge clk);
            if (a_wren) begin
                if (exp_a.size() == 0) checkOutput("a_unexpected", a_wren, 0);
                else checkOutput("a_row", a_row, exp_a.pop_front());
            end
            if (b_wren) begin
                if (exp_b.size() == 0) begin
                    checkOutput("b_unexpected", b_wren, 0);
                end else begin
                    checkOutput("b_byte", b_byte, exp_b.pop_front());
                    if (b_count == 0) b_first = cyc - start_cyc;
                    b_last = cyc - start_cyc;
                    b_count++;
                end
            end
            if (clr) clr_count++;
            if (a_wren || b_wren || clr) checkOutput("exclusive", $countones({a_wren, b_wren, clr}), 1);
        end
    end

    initial begin
        int end_cyc;
        int w;
        logic [DW-1:0] byte3;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_clr", clr, 0);
        checkOutput("rst_read", mem.read, 0);
        checkOutput("rst_addr", mem.address, BASE);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_wren", {a_wren, b_wren}, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] job 1: directed zero-wait, start pulsed mid-job");
        fillLines(1'b1);
        applyStimulus(DEP, DEP);
        waitJob(10, end_cyc);
        checkJob(0, 1'b1, end_cyc);
        repeat (3) begin
            @(negedge clk);
            checkOutput("done_held", done, 1);
        end

        $display("[TB] job 2: restart from DONE with the same data");
        applyStimulus(DEP, DEP);
        waitJob(-1, end_cyc);
        checkJob(0, 1'b1, end_cyc);

        $display("[TB] job 3: 5-cycle stall on line 3 with spurious readdatavalid");
        fillLines(1'b0);
        stall_line    = 3;
        stall_left    = 5;
        stall_started = 1'b0;
        spurious      = 1'b1;
        applyStimulus(DEP, DEP);
        waitJob(-1, end_cyc);
        checkJob(5, 1'b1, end_cyc);
        checkOutput("stall_consumed", stall_left, 0);
        stall_left = 0;
        spurious   = 1'b0;

        $display("[TB] job 4: line 4 never returns");
        fillLines(1'b0);
        drop_line = 4;
        applyStimulus(4, 0);
        waitJob(-1, end_cyc);
        checkOutput("to_err", err, 1);
        checkOutput("to_busy", busy, 0);
        checkOutput("to_done", done, 0);
        checkOutput("to_accepts", accept_count, 5);
        checkOutput("to_a_left", exp_a.size(), 0);
        checkOutput("to_b_count", b_count, 0);
        w = start_cyc + end_cyc - accept_cyc - 1;
        checkOutput("to_wait_len_ok", (w == TMO) || (w == TMO + 1), 1);
        drop_line = -1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("err_held", err, 1);
            checkOutput("err_no_read", mem.read, 0);
        end

        $display("[TB] job 5: restart from ERROR");
        fillLines(1'b0);
        applyStimulus(DEP, DEP);
        waitJob(-1, end_cyc);
        checkJob(0, 1'b1, end_cyc);

        $display("[TB] job 6: reset during STREAM_B at byte 3");
        fillLines(1'b0);
        byte3 = lines[DEP][LW-1-3*DW -: DW];
        applyStimulus(DEP, 4);
        repeat (22) @(negedge clk);
        checkOutput("byte3_wren", b_wren, 1);
        checkOutput("byte3_value", b_byte, byte3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_outputs", {clr, a_wren, b_wren, mem.read, busy, done, err}, 0);
        checkOutput("abort_addr", mem.address, BASE);
        checkOutput("abort_a_row", a_row, 0);
        checkOutput("abort_b_byte", b_byte, 0);
        checkOutput("abort_b_count", b_count, 4);
        stray = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("stray_wren", {a_wren, b_wren}, 0);
            checkOutput("stray_busy", busy, 0);
        end
        stray = 1'b0;
        @(negedge clk);
        checkOutput("stray_after", {a_wren, b_wren}, 0);

        $display("[TB] jobs 7-10: random waitrequest and latency");
        rand_wait = 1'b1;
        rand_lat  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            fillLines(1'b0);
            applyStimulus(DEP, DEP);
            waitJob(-1, end_cyc);
            checkJob(0, 1'b0, end_cyc);
        end
        rand_wait = 1'b0;
        rand_lat  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
